ripple_adder_5_bit: RTL and testbench

5-bit ripple-carry adder built from a chain of 1-bit full-adder cells. It provides a combinational sum/carry path plus a registered copy of the result. It is used as the basic datapath adder in lab ALU blocks. It also serves as the reference structural adder that datapath units compare against.

---
 rtl/ripple_adder_pkg.sv | 8 +
 rtl/ripple_adder_5_bit_full_adder_cell.sv | 11 +
 rtl/ripple_adder_5_bit.sv | 55 +++++
 tb/tb_ripple_adder_5_bit.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/ripple_adder_pkg.sv
// ripple_adder_pkg: shared width and result type for the ripple-carry adder
package ripple_adder_pkg;
  localparam int ADDER_WIDTH = 5;
  typedef struct packed {
    logic                   cout;
    logic [ADDER_WIDTH-1:0] sum;
  } adder_result_t;
endpackage

// File: rtl/ripple_adder_5_bit_full_adder_cell.sv
// full_adder_cell: single-bit full adder used as the ripple stage
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/ripple_adder_5_bit.sv
// ripple_adder_5_bit: 5-bit ripple-carry adder with registered result copy
// Defining RIPPLE_ADDER_OVF_EN adds signed-overflow outputs ovf and ovf_r.
module ripple_adder_5_bit
  import ripple_adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             en,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_r,
  output logic             cout_r
`ifdef RIPPLE_ADDER_OVF_EN
  ,
  output logic             ovf,
  output logic             ovf_r
`endif
);
  logic [WIDTH:0] c;
  adder_result_t  res_d, res_q;
  assign c[0] = cin;
  genvar i;
  for (i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_cell u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .cin(c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end
  assign cout = c[WIDTH];
  always_comb res_d = en ? adder_result_t'{cout: cout, sum: sum} : res_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) res_q <= '0;
    else     res_q <= res_d;
  assign sum_r  = res_q.sum;
  assign cout_r = res_q.cout;
`ifdef RIPPLE_ADDER_OVF_EN
  logic ovf_d, ovf_q;
  assign ovf = c[WIDTH] ^ c[WIDTH-1];
  always_comb ovf_d = en ? ovf : ovf_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  assign ovf_r = ovf_q;
`else
  // carry into the top bit only matters for overflow detection
`endif
endmodule

// File: tb/tb_ripple_adder_5_bit.sv
// tb_ripple_adder_5_bit: directed, exhaustive and randomized checks of the adder
module tb_ripple_adder_5_bit;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] a = '0, b = '0;
  logic       cin = 1'b0, en = 1'b0;
  logic [4:0] sum, sum_r;
  logic       cout, cout_r;
  int         n_checks = 0, n_fail = 0;
  int         exp_sum_r = 0, exp_cout_r = 0, exp_ovf_r = 0;
`ifdef RIPPLE_ADDER_OVF_EN
  logic       ovf, ovf_r;
`endif

  ripple_adder_5_bit dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .en    (en),
    .sum   (sum),
    .cout  (cout),
    .sum_r (sum_r),
    .cout_r(cout_r)
`ifdef RIPPLE_ADDER_OVF_EN
    ,
    .ovf   (ovf),
    .ovf_r (ovf_r)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_total(input int x, input int y, input int ci);
    return x + y + ci;
  endfunction

  function automatic int model_ovf(input int x, input int y, input int ci);
    int sx, sy, t;
    sx = (x >= 16) ? x - 32 : x;
    sy = (y >= 16) ? y - 32 : y;
    t  = sx + sy + ci;
    return (t > 15 || t < -16) ? 1 : 0;
  endfunction

  task automatic check_comb(input string tag);
    int t;
    t = model_total(int'(a), int'(b), int'(cin));
    check({tag, "_sum"}, int'(sum), t % 32);
    check({tag, "_cout"}, int'(cout), t / 32);
`ifdef RIPPLE_ADDER_OVF_EN
    check({tag, "_ovf"}, int'(ovf), model_ovf(int'(a), int'(b), int'(cin)));
`endif
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_sum_r"}, int'(sum_r), exp_sum_r);
    check({tag, "_cout_r"}, int'(cout_r), exp_cout_r);
`ifdef RIPPLE_ADDER_OVF_EN
    check({tag, "_ovf_r"}, int'(ovf_r), exp_ovf_r);
`endif
  endtask

  task automatic model_load();
    int t;
    t = model_total(int'(a), int'(b), int'(cin));
    exp_sum_r  = t % 32;
    exp_cout_r = t / 32;
    exp_ovf_r  = model_ovf(int'(a), int'(b), int'(cin));
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 check_regs("reset");
    a = 5'b01100; b = 5'b10011; cin = 1'b0;
    #1 check("tp1_sum", int'(sum), 31);
    check("tp1_cout", int'(cout), 0);
    cin = 1'b1;
    #1 check("tp2_sum", int'(sum), 0);
    check("tp2_cout", int'(cout), 1);
    a = 5'b01001; b = 5'b11011; cin = 1'b1;
    #1 check("tp3_sum", int'(sum), 5);
    check("tp3_cout", int'(cout), 1);
    a = 5'b01111; b = 5'b00001; cin = 1'b0;
    #1 check("tp4_sum", int'(sum), 16);
    check("tp4_cout", int'(cout), 0);
`ifdef RIPPLE_ADDER_OVF_EN
    check("tp4_ovf", int'(ovf), 1);
`endif
    a = 5'b11111; b = 5'b11111; cin = 1'b1;
    #1 check_comb("allones");
    @(negedge clk);
    rst = 1'b0;
    a = 5'b01001; b = 5'b11011; cin = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    check("load_sum_r", int'(sum_r), 5);
    check("load_cout_r", int'(cout_r), 1);
    exp_sum_r = 5; exp_cout_r = 1; exp_ovf_r = 0;
    @(negedge clk);
    en = 1'b0; a = 5'b00011; b = 5'b00100; cin = 1'b0;
    @(posedge clk); #1;
    check_regs("hold");
    #2 rst = 1'b1;
    #1 exp_sum_r = 0; exp_cout_r = 0; exp_ovf_r = 0;
    check_regs("midrst");
    check_comb("midrst_comb");
    @(negedge clk);
    a = 5'b10101; b = 5'b01110; cin = 1'b1; en = 1'b1;
    rst = 1'b0;
    @(posedge clk); #1;
    model_load();
    check_regs("rst_release");
    en = 1'b0;
    for (int x = 0; x < 32; x++)
      for (int y = 0; y < 32; y++)
        for (int ci = 0; ci < 2; ci++) begin
          a = 5'(x); b = 5'(y); cin = 1'(ci);
          #1 check_comb("exh");
        end
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      a = 5'($urandom_range(0, 31)); b = 5'($urandom_range(0, 31));
      cin = 1'($urandom_range(0, 1)); en = 1'($urandom_range(0, 1));
      #1 check_comb("rnd");
      @(posedge clk);
      if (en) model_load();
      #1 check_regs("rnd");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
